// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller: FSM state encoding and
// the PWM period, which is also the default upper duty limit.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BREATHE_UP = 2'd1,
    BREATHE_DN = 2'd2
  } state_e;

  localparam int PWM_PERIOD = 1000;

endpackage

// File: rtl/btn_debounce.sv
// One button front end: 2-flop synchronizer, debounce counter, and a
// single-cycle press pulse on the debounced rising edge.
//
// After reset the debouncer is disarmed. It arms only once the synchronized
// input has been low for DEBOUNCE_CYCLES consecutive cycles. A button that
// is held through reset release therefore cannot produce a press until it
// has been let go and pressed again. The two synchronizer flops read 0 for
// up to two cycles after reset, so DEBOUNCE_CYCLES should be at least 3.
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          count_en;

  // Synchronizer, debounce state and press pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive cycles of disagreement (armed) or of a released
  // button (disarmed); act when the count reaches DEBOUNCE_CYCLES.
  always_comb begin
    level_d  = level_q;
    armed_d  = armed_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    count_en = armed_q ? (sync2_q != level_q) : !sync2_q;
    if (count_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (armed_q) begin
          level_d = !level_q;
          press_d = !level_q;
        end else begin
          armed_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM duty controller: manual up/down stepping with saturation and an
// optional breathing mode that ramps the duty between 0 and MAX_DUTY.
// Breathing mode is built only when PWM_FADE_AUTO_EN is defined; otherwise
// btn_auto is ignored and breathing is tied low.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000,
  parameter int STEP            = 100,
  parameter int MAX_DUTY        = PWM_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_auto,
  output logic [9:0] duty_cmd,
  output logic       breathing,
  output logic       at_max,
  output logic       at_min
);

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] MAX_W  = 11'(MAX_DUTY);

  logic        up_p, dn_p;
  logic [9:0]  duty_q, duty_d;
  logic        at_max_q, at_min_q;
  logic [10:0] sum_up, diff_dn;
  logic [9:0]  manual_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up), .press(up_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk(clk), .rst(rst), .btn_raw(btn_dn), .press(dn_p)
  );

  // Manual step target: 11-bit saturating add/subtract, no change when both
  // buttons fire in the same cycle.
  always_comb begin
    sum_up   = {1'b0, duty_q} + STEP_W;
    diff_dn  = {1'b0, duty_q} - STEP_W;
    manual_d = duty_q;
    if (up_p && !dn_p) begin
      manual_d = (sum_up > MAX_W) ? MAX_W[9:0] : sum_up[9:0];
    end else if (dn_p && !up_p) begin
      manual_d = diff_dn[10] ? 10'd0 : diff_dn[9:0];
    end
  end

`ifdef PWM_FADE_AUTO_EN
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic          auto_p;
  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_auto (
    .clk(clk), .rst(rst), .btn_raw(btn_auto), .press(auto_p)
  );

  // FSM state and breathing tick counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  // Next state, tick and duty; auto press wins over everything else.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    duty_d  = duty_q;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (auto_p) begin
          state_d = ({1'b0, duty_q} < MAX_W) ? BREATHE_UP : BREATHE_DN;
        end else begin
          duty_d = manual_d;
        end
      end
      BREATHE_UP: begin
        if (auto_p) begin
          state_d = IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          duty_d = duty_q + 10'd1;
          if ({1'b0, duty_d} == MAX_W) state_d = BREATHE_DN;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      BREATHE_DN: begin
        if (auto_p) begin
          state_d = IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          duty_d = duty_q - 10'd1;
          if (duty_d == 10'd0) state_d = BREATHE_UP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  assign breathing = (state_q != IDLE);
`else
  logic unused_auto;
  assign unused_auto = btn_auto;

  // Manual stepping only.
  always_comb begin
    duty_d = manual_d;
  end

  assign breathing = 1'b0;
`endif

  // Duty command and its limit flags, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q   <= '0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      duty_q   <= duty_d;
      at_max_q <= ({1'b0, duty_d} == MAX_W);
      at_min_q <= (duty_d == 10'd0);
    end
  end

  assign duty_cmd = duty_q;
  assign at_max   = at_max_q;
  assign at_min   = at_min_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl. Stimulus pushes the expected output
// snapshot for every change it causes; a monitor compares each observed
// change of {duty_cmd, breathing, at_max, at_min} against the queue head.
// Breathing checks are compiled in when PWM_FADE_AUTO_EN is defined.
module tb_pwm_fade_ctrl;

  typedef struct packed {
    logic [9:0] duty;
    logic       br;
    logic       mx;
    logic       mn;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_dn = 1'b0, btn_auto = 1'b0;
  logic [9:0] duty_cmd;
  logic       breathing, at_max, at_min;

  snap_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_en = 1'b0;

  pwm_fade_ctrl #(
    .DEBOUNCE_CYCLES(4), .TICK_CYCLES(3), .STEP(100), .MAX_DUTY(1000)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .btn_auto(btn_auto), .duty_cmd(duty_cmd), .breathing(breathing),
    .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input int d, input bit b);
    snap_t s;
    s.duty = 10'(d);
    s.br   = b;
    s.mx   = (d == 1000);
    s.mn   = (d == 0);
    return s;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit u, input bit d, input bit a);
    btn_up = u; btn_dn = d; btn_auto = a;
    cyc(10);
    btn_up = 1'b0; btn_dn = 1'b0; btn_auto = 1'b0;
    cyc(12);
  endtask

  // Start breathing, then stop it so that exactly n ticks land in between.
  task automatic breathe_run(input int n);
    btn_auto = 1'b1;
    cyc(10);
    btn_auto = 1'b0;
    cyc(3 * n + 1 - 10);
    btn_auto = 1'b1;
    cyc(10);
    btn_auto = 1'b0;
    cyc(12);
  endtask

  // Monitor: every change of the observed outputs is one transaction.
  initial begin
    snap_t prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {duty_cmd, breathing, at_max, at_min};
      if (mon_en && cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change: got duty=%0d br=%0b max=%0b min=%0b, required no change",
                   cur.duty, cur.br, cur.mx, cur.mn);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            miscompares++;
            $display("FAIL output_change: got duty=%0d br=%0b max=%0b min=%0b, required duty=%0d br=%0b max=%0b min=%0b",
                     cur.duty, cur.br, cur.mx, cur.mn, e.duty, e.br, e.mx, e.mn);
          end else begin
            $display("vec %0d: duty=%0d br=%0b max=%0b min=%0b ok",
                     vectors, cur.duty, cur.br, cur.mx, cur.mn);
          end
        end
      end
      prev = cur;
    end
  end

  // Watchdog: the stimulus never waits on the DUT, but never hang regardless.
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    snap_t r;
    cyc(3);
    @(negedge clk);
    r = {duty_cmd, breathing, at_max, at_min};
    vectors++;
    if (r !== mk(0, 0)) begin
      miscompares++;
      $display("FAIL reset_state: got duty=%0d br=%0b max=%0b min=%0b, required duty=0 br=0 max=0 min=1",
               r.duty, r.br, r.mx, r.mn);
    end else begin
      $display("vec %0d: reset state ok", vectors);
    end
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(8);

    // Single steady press, then a short glitch that must be rejected.
    exp_q.push_back(mk(100, 0));
    press(1, 0, 0);
    btn_up = 1'b1; cyc(2); btn_up = 1'b0; cyc(12);

    // Ten more up presses: 200..1000, the last one saturates silently.
    for (int i = 2; i <= 10; i++) exp_q.push_back(mk(i * 100, 0));
    for (int i = 0; i < 10; i++) press(1, 0, 0);
    exp_q.push_back(mk(900, 0));
    press(0, 1, 0);

`ifdef PWM_FADE_AUTO_EN
    // Ramp 900 -> 998 and stop.
    exp_q.push_back(mk(900, 1));
    for (int d = 901; d <= 998; d++) exp_q.push_back(mk(d, 1));
    exp_q.push_back(mk(998, 0));
    breathe_run(98);

    // Turnaround at the top: 999, 1000, then down to 995, stop holds duty.
    exp_q.push_back(mk(998, 1));
    exp_q.push_back(mk(999, 1));
    exp_q.push_back(mk(1000, 1));
    for (int d = 999; d >= 995; d--) exp_q.push_back(mk(d, 1));
    exp_q.push_back(mk(995, 0));
    breathe_run(7);

    // Ramp up to 1000 and down to 700, then reset with btn_up held.
    exp_q.push_back(mk(995, 1));
    for (int d = 996; d <= 1000; d++) exp_q.push_back(mk(d, 1));
    for (int d = 999; d >= 700; d--) exp_q.push_back(mk(d, 1));
    exp_q.push_back(mk(0, 0));
    btn_auto = 1'b1;
    cyc(10);
    btn_auto = 1'b0;
    cyc(790);
    btn_up = 1'b1;
    cyc(122);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
`else
    // Auto button has no effect without breathing support.
    press(0, 0, 1);

    // Reset with btn_up held, before its press could complete.
    exp_q.push_back(mk(0, 0));
    btn_up = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
`endif
    cyc(20);
    btn_up = 1'b0;
    cyc(12);
    exp_q.push_back(mk(100, 0));
    press(1, 0, 0);

    // Down to 0, then a down press at the floor.
    exp_q.push_back(mk(0, 0));
    press(0, 1, 0);
    press(0, 1, 0);

    // Up to 500, then simultaneous up/down.
    for (int i = 1; i <= 5; i++) exp_q.push_back(mk(i * 100, 0));
    for (int i = 0; i < 5; i++) press(1, 0, 0);
    press(1, 1, 0);

    cyc(20);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expected: got %0d entries left, required 0", exp_q.size());
    end else begin
      $display("vec %0d: scoreboard drained ok", vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, cycles a raw button must be stable before it is accepted.
REQ-002 SHALL have parameter TICK_CYCLES, default 50000, clock cycles per breathing step.
REQ-003 SHALL have parameter STEP, default 100, duty increment/decrement per manual press.
REQ-004 SHALL have parameter MAX_DUTY, default 1000, upper duty limit; equals the PWM period.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 btn_up  in  1  raw asynchronous button, manual duty up.
REQ-008 btn_dn  in  1  raw asynchronous button, manual duty down.
REQ-009 btn_auto  in  1  raw asynchronous button, breathing mode toggle.
REQ-010 duty_cmd  out  10  registered duty command, range 0..MAX_DUTY, drives the PWM duty input.
REQ-011 breathing  out  1  high while in BREATHE_UP or BREATHE_DN.
REQ-012 at_max  out  1  registered; high when duty_cmd == MAX_DUTY.
REQ-013 at_min  out  1  registered; high when duty_cmd == 0.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer followed by a debouncer. The debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 Each debouncer SHALL emit a 1-cycle press pulse on the debounced 0->1 transition only.
REQ-016 The FSM SHALL have states IDLE, BREATHE_UP and BREATHE_DN, with reset state IDLE.
REQ-017 IDLE, up pulse only: duty_cmd SHALL become min(duty_cmd+STEP, MAX_DUTY) on the next clock.
REQ-018 IDLE, dn pulse only: duty_cmd SHALL become max(duty_cmd-STEP, 0) on the next clock. Arithmetic SHALL be 11-bit so no wrap occurs.
REQ-019 IDLE, up and dn pulses in the same cycle: no duty change.
REQ-020 IDLE, auto pulse: go to BREATHE_UP if duty_cmd < MAX_DUTY, else BREATHE_DN. The tick counter SHALL clear. Auto SHALL have priority over up/dn in the same cycle.
REQ-021 The tick counter SHALL count 0..TICK_CYCLES-1 only in breathing states. A tick fires when it wraps.
REQ-022 BREATHE_UP, on tick: duty_cmd+1. When the new value equals MAX_DUTY, go to BREATHE_DN.
REQ-023 BREATHE_DN, on tick: duty_cmd-1. When the new value equals 0, go to BREATHE_UP.
REQ-024 Breathing states, auto pulse: go to IDLE and hold the current duty_cmd. Up/dn pulses SHALL be ignored in breathing states.
REQ-025 at_max, at_min and breathing SHALL reflect the registered state/duty with no combinational path from the buttons.

Reset
REQ-026 On rst, the following SHALL all clear: duty_cmd=0, state=IDLE, tick counter=0, debounced levels=0, debounce counters=0, synchronizer flops=0. Outputs: breathing=0, at_max=0, at_min=1.
REQ-027 rst SHALL take effect in any state, including mid-debounce and mid-breathing. No press pulse SHALL be generated by reset release while a button is held; the press requires a full debounce after release.

Configuration
REQ-028 Macro PWM_FADE_AUTO_EN defined: breathing mode is present as specified.
REQ-029 PWM_FADE_AUTO_EN undefined: btn_auto debouncer, tick counter and breathing states are absent; btn_auto is ignored; breathing is tied 0; only manual stepping remains.

Structure
REQ-030 Shared package pwm_pkg SHALL hold the FSM state enum (IDLE, BREATHE_UP, BREATHE_DN) and the constant PWM_PERIOD=1000. MAX_DUTY defaults to PWM_PERIOD.
REQ-031 Sub-module btn_debounce (synchronizer, debounce counter, press pulse) SHALL be instantiated once per button.

Verification (bench overrides: DEBOUNCE_CYCLES=4, TICK_CYCLES=3, STEP=100, MAX_DUTY=1000)
REQ-032 Press btn_up steady 10 cycles from reset -> duty_cmd 0->100 exactly once, at_min drops. A 2-cycle glitch -> no change.
REQ-033 Eleven separate up presses -> duty_cmd saturates at 1000, at_max=1. Then one dn press -> 900.
REQ-034 With duty 0, press dn -> stays 0. Press up and dn simultaneously at duty 500 -> stays 500.
REQ-035 Auto press at duty 998 -> breathing=1; after 2 ticks (6 cycles) duty 1000, then state BREATHE_DN, next tick 999. Auto press -> IDLE, duty held.
REQ-036 Assert rst during BREATHE_DN at duty 700 with btn_up held -> next cycle duty 0, IDLE, at_min=1. No press pulse until btn_up released and re-pressed.
REQ-037 Build without PWM_FADE_AUTO_EN, auto press -> breathing stays 0, duty unchanged.
